// File: rtl/count_game_pkg.sv
// Shared types and constants for the count game controller.
// Leading-zero blanking is enabled by defining COUNT_GAME_LZB_EN.
package count_game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [7:0] DIG_OFF    = 8'hFF;

endpackage

// File: rtl/count_game_ctrl_bcd_digit.sv
// One decade of the BCD stopwatch chain.
// Exposes both the held value and the value it will take next clock.
module bcd_digit
  import count_game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] val,
  output logic [BCD_W-1:0] nxt,
  output logic             co
);

  logic at9;

  assign at9 = (val == BCD_W'(9));
  assign co  = inc & at9;

  always_comb begin
    nxt = val;
    if (clr)
      nxt = '0;
    else if (inc)
      nxt = at9 ? '0 : val + BCD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      val <= '0;
    else
      val <= nxt;
  end

endmodule

// File: rtl/count_game_ctrl.sv
// BCD stopwatch with start/stop/clear and multiplexed digit scan.
// Define COUNT_GAME_LZB_EN for leading-zero blanking on num.
module count_game_ctrl
  import count_game_pkg::*;
#(
  parameter int NDIG     = 2,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       clr,
  output logic [3:0] num,
  output logic [7:0] dig,
  output logic       running,
  output logic       wrap
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic s1, s2, s3;
  logic st_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= st;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign st_pulse = s2 & ~s3;

  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (st_pulse) begin
      unique case (state)
        IDLE: begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: begin
          state   <= STOP;
          running <= 1'b0;
        end
        STOP: begin
          state   <= RUN;
          running <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  logic [TW-1:0] pre;
  logic          tick;

  assign tick = (state == RUN) &&
                (pre == TW'(TICK_DIV - 1));

  // Any exit from RUN restarts the prescaler from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pre <= '0;
    else if (state != RUN || clr || st_pulse || tick)
      pre <= '0;
    else
      pre <= pre + TW'(1);
  end

  logic [NDIG:0]            cy;
  logic [NDIG*BCD_W-1:0]    val;
  logic [NDIG*BCD_W-1:0]    nxt;

  assign cy[0] = tick;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (cy[i]),
      .val (val[i*BCD_W +: BCD_W]),
      .nxt (nxt[i*BCD_W +: BCD_W]),
      .co  (cy[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wrap <= 1'b0;
    else
      wrap <= cy[NDIG] & ~clr;
  end

  logic [SW-1:0] scnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic          adv;

  assign adv = (scnt == SW'(SCAN_DIV - 1));

  always_comb begin
    idx_n = idx;
    if (adv)
      idx_n = (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
  end

  logic [3:0] cur;
  logic       blank;

  // Built from next-state values so num tracks same-cycle increments
  always_comb begin
    cur   = nxt[idx_n*BCD_W +: BCD_W];
    blank = 1'b0;
`ifdef COUNT_GAME_LZB_EN
    blank = (idx_n != '0);
    for (int j = 0; j < NDIG; j++)
      if (IW'(j) >= idx_n && nxt[j*BCD_W +: BCD_W] != '0)
        blank = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      idx  <= '0;
      num  <= 4'h0;
      dig  <= 8'hFE;
    end else begin
      scnt <= adv ? '0 : scnt + SW'(1);
      idx  <= idx_n;
      num  <= blank ? BLANK_CODE : cur;
      dig  <= DIG_OFF ^ (8'h01 << idx_n);
    end
  end

endmodule

// File: tb/tb_count_game_ctrl.sv
// Scoreboard bench for count_game_ctrl (NDIG=2, TICK_DIV=4, SCAN_DIV=2).
// Expected scan slots are queued by stimulus and checked by a monitor.
module tb_count_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       st;
  logic       clr;
  logic [3:0] num;
  logic [7:0] dig;
  logic       running;
  logic       wrap;

  localparam logic [7:0] FE = 8'hFE;
  localparam logic [7:0] FD = 8'hFD;
`ifdef COUNT_GAME_LZB_EN
  localparam logic [3:0] Z1 = 4'hF;
`else
  localparam logic [3:0] Z1 = 4'h0;
`endif

  count_game_ctrl #(
    .NDIG     (2),
    .TICK_DIV (4),
    .SCAN_DIV (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .st      (st),
    .clr     (clr),
    .num     (num),
    .dig     (dig),
    .running (running),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] key;
    bit         exact;
    logic [3:0] num;
    bit         run;
    bit         wrap;
  } exp_t;

  exp_t q[$];
  int   ntest = 0;
  int   nfail = 0;

  task automatic chk(input string n, input logic [7:0] k,
                     input bit ex, input logic [3:0] nm,
                     input bit r, input bit w);
    exp_t e;
    e.name  = n;
    e.key   = k;
    e.exact = ex;
    e.num   = nm;
    e.run   = r;
    e.wrap  = w;
    q.push_back(e);
  endtask

  // key==0: check status now; exact: slot must be key now;
  // otherwise wait for the matching scan slot
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit   bad;
      e = q[0];
      if (e.key == 8'h00 || e.exact || dig == e.key) begin
        void'(q.pop_front());
        bad = 1'b0;
        if (e.exact && dig !== e.key) bad = 1'b1;
        if (e.key != 8'h00 && num !== e.num) bad = 1'b1;
        if (running !== e.run) bad = 1'b1;
        if (wrap !== e.wrap) bad = 1'b1;
        ntest++;
        if (bad) begin
          nfail++;
          $display("FAIL %s: got dig=%h num=%h run=%b wrap=%b, want dig=%h num=%h run=%b wrap=%b",
                   e.name, dig, num, running, wrap,
                   e.key, e.num, e.run, e.wrap);
        end
      end
    end
  end

  task automatic drain(input int n);
    int k = 0;
    while (q.size() > 0 && k < n) begin
      @(posedge clk);
      k++;
    end
    if (q.size() > 0) begin
      ntest++;
      nfail++;
      $display("FAIL timeout %s: %0d checks pending, want 0",
               q[0].name, q.size());
      q.delete();
    end
  endtask

  task automatic press();
    #2 st = 1'b1;
    @(posedge clk);
    #2 st = 1'b0;
  endtask

  task automatic clear();
    @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    st  = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    chk("rst_hold", FE, 1, 4'h0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    drain(10);

    @(posedge clk);
    press();
    @(posedge clk);
    chk("pre_run", 8'h00, 0, 4'h0, 0, 0);
    @(posedge clk);
    chk("run_on", 8'h00, 0, 4'h0, 1, 0);
    repeat (52) @(posedge clk);
    press();
    repeat (3) @(posedge clk);
    chk("c13_d0", FE, 0, 4'h3, 0, 0);
    chk("c13_d1", FD, 0, 4'h1, 0, 0);
    drain(20);

    @(posedge clk);
    press();
    @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk);
    chk("clr_pri", 8'h00, 0, 4'h0, 0, 0);
    #2 clr = 1'b0;
    repeat (10) @(posedge clk);
    chk("clr_d0", FE, 0, 4'h0, 0, 0);
    chk("clr_d1", FD, 0, Z1, 0, 0);
    drain(20);

    @(posedge clk);
    press();
    repeat (2) @(posedge clk);
    chk("run2", 8'h00, 0, 4'h0, 1, 0);
    repeat (28) @(posedge clk);
    press();
    repeat (100) @(posedge clk);
    chk("c07_d0", FE, 0, 4'h7, 0, 0);
    chk("c07_d1", FD, 0, Z1, 0, 0);
    drain(20);

    @(posedge clk);
    press();
    repeat (2) @(posedge clk);
    chk("resume", 8'h00, 0, 4'h0, 1, 0);
    @(posedge clk);
    press();
    @(posedge clk);
    chk("run_e3", 8'h00, 0, 4'h0, 1, 0);
    @(posedge clk);
    chk("stop_e4", 8'h00, 0, 4'h0, 0, 0);
    chk("c08_d0", FE, 0, 4'h8, 0, 0);
    drain(20);

    @(posedge clk);
    press();
    repeat (2) @(posedge clk);
    chk("resume2", 8'h00, 0, 4'h0, 1, 0);
    press();
    repeat (2) @(posedge clk);
    chk("stop_e3", 8'h00, 0, 4'h0, 0, 0);
    chk("c08b_d0", FE, 0, 4'h8, 0, 0);
    drain(20);

    clear();
    @(posedge clk);
    press();
    repeat (2) @(posedge clk);
    repeat (399) @(posedge clk);
    chk("pre_wrap", 8'h00, 0, 4'h0, 1, 0);
    @(posedge clk);
    chk("wrap", 8'h00, 0, 4'h0, 1, 1);
    @(posedge clk);
    chk("post_wrap", 8'h00, 0, 4'h0, 1, 0);
    repeat (3) @(posedge clk);
    press();
    repeat (3) @(posedge clk);
    chk("c01_d0", FE, 0, 4'h1, 0, 0);
    chk("c01_d1", FD, 0, Z1, 0, 0);
    drain(20);

    clear();
    @(posedge clk);
    press();
    repeat (2) @(posedge clk);
    repeat (20) @(posedge clk);
    press();
    repeat (3) @(posedge clk);
    chk("c05_d0", FE, 0, 4'h5, 0, 0);
    chk("c05_d1", FD, 0, Z1, 0, 0);
    drain(20);
    clear();
    chk("c00_d0", FE, 0, 4'h0, 0, 0);
    chk("c00_d1", FD, 0, Z1, 0, 0);
    drain(20);

    @(posedge clk);
    press();
    repeat (2) @(posedge clk);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", FE, 1, 4'h0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      if (((k / 2) % 2) == 1)
        chk("scan", FD, 1, Z1, 0, 0);
      else
        chk("scan", FE, 1, 4'h0, 0, 0);
    end
    drain(10);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
